// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment constants, decode helper and reader state type
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] digit;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_digit(input logic [6:0] seg);
        seg_dec_t d;
        d.legal = 1'b1;
        d.blank = 1'b0;
        d.digit = 4'd0;
        case (seg)
            SEG_0: d.digit = 4'd0;
            SEG_1: d.digit = 4'd1;
            SEG_2: d.digit = 4'd2;
            SEG_3: d.digit = 4'd3;
            SEG_4: d.digit = 4'd4;
            SEG_5: d.digit = 4'd5;
            SEG_6: d.digit = 4'd6;
            SEG_7: d.digit = 4'd7;
            SEG_8: d.digit = 4'd8;
            SEG_9: d.digit = 4'd9;
            SEG_BLANK: begin
                d.legal = 1'b0;
                d.blank = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// rtl/seg_stable_filter.sv - input register plus stability counter; pulses accept once per stable run
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    output logic       accept,
    output logic [6:0] pattern
);

    localparam logic [3:0] CNT_SAT  = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    logic [6:0] seg_q;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'd0;
            cnt   <= 4'd0;
        end else begin
            seg_q <= segments;
            if (segments != seg_q) begin
                cnt <= 4'd0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // The counter only passes through CNT_LAST for one cycle per run, so this fires once.
    assign accept  = (cnt == CNT_LAST);
    assign pattern = seg_q;

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - decodes a filtered segment bus, checks +1 sequencing, measures period
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          segments,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                change_strobe,
    output logic                seq_err,
    output logic                bad_pattern,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          err_count
);

    logic                accept;
    logic [6:0]          pattern;
    seg_dec_t            dec;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [3:0]          digit_d;
    logic                valid_d, chg_d, seq_d, bad_d;
    logic [PERIOD_W-1:0] period_d;
    logic [7:0]          err_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .segments(segments),
        .accept  (accept),
        .pattern (pattern)
    );

    assign dec = seg_to_digit(pattern);

    always_comb begin
        state_d  = state_q;
        digit_d  = digit;
        valid_d  = digit_valid;
        chg_d    = 1'b0;
        seq_d    = 1'b0;
        bad_d    = 1'b0;
        period_d = period;
        err_d    = err_count;
        pcnt_d   = pcnt_q;
        if (state_q == TRACK && pcnt_q != '1) begin
            pcnt_d = pcnt_q + PERIOD_W'(1);
        end

        // Blank frames are treated as "display off" and leave everything untouched.
        if (accept && !dec.blank) begin
            if (!dec.legal) begin
                bad_d   = 1'b1;
                valid_d = 1'b0;
                state_d = SYNC;
            end else begin
                case (state_q)
                    SYNC: begin
                        digit_d = dec.digit;
                        valid_d = 1'b1;
                        chg_d   = 1'b1;
                        pcnt_d  = '0;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (dec.digit != digit) begin
                            digit_d  = dec.digit;
                            chg_d    = 1'b1;
                            period_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);
                            pcnt_d   = '0;
                            seq_d    = (dec.digit != next_digit(digit));
                        end
                    end
                    default: state_d = SYNC;
                endcase
            end
        end

        if ((seq_d || bad_d) && err_count != 8'hFF) begin
            err_d = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SYNC;
            pcnt_q        <= '0;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            change_strobe <= 1'b0;
            seq_err       <= 1'b0;
            bad_pattern   <= 1'b0;
            period        <= '0;
            err_count     <= 8'd0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            digit         <= digit_d;
            digit_valid   <= valid_d;
            change_strobe <= chg_d;
            seq_err       <= seq_d;
            bad_pattern   <= bad_d;
            period        <= period_d;
            err_count     <= err_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - directed self-checking bench for seven_segment_reader
module tb_seven_segment_reader;

    logic        clk;
    logic        rst;
    logic [6:0]  segments;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        change_strobe;
    logic        seq_err;
    logic        bad_pattern;
    logic [23:0] period;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int chg_n    = 0;
    int seq_n    = 0;
    int bad_n    = 0;
    int chg_mark;

    logic [6:0] pat [10];

    seven_segment_reader #(
        .STABLE_CYCLES(4),
        .PERIOD_W     (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .segments     (segments),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .change_strobe(change_strobe),
        .seq_err      (seq_err),
        .bad_pattern  (bad_pattern),
        .period       (period),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (change_strobe) chg_n++;
        if (seq_err)       seq_n++;
        if (bad_pattern)   bad_n++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] seg);
        @(posedge clk);
        #1;
        segments = seg;
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        drive(seg);
        wait_edges(n - 1);
    endtask

    initial begin
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
        pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h6F;

        rst      = 1'b1;
        segments = 7'h00;
        wait_edges(3);
        check_eq("rst_digit", 32'(digit), 0);
        check_eq("rst_valid", 32'(digit_valid), 0);
        check_eq("rst_period", 32'(period), 0);
        check_eq("rst_err", 32'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // first acceptance in SYNC, exact latency
        drive(7'h3F);
        wait_edges(4);
        check_eq("t1_early_valid", 32'(digit_valid), 0);
        wait_edges(1);
        check_eq("t1_digit", 32'(digit), 0);
        check_eq("t1_valid", 32'(digit_valid), 1);
        check_eq("t1_chg", 32'(change_strobe), 1);
        check_eq("t1_period", 32'(period), 0);
        check_eq("t1_err", 32'(err_count), 0);
        wait_edges(1);
        check_eq("t1_chg_width", 32'(change_strobe), 0);
        wait_edges(4);

        // full count 1..9 then wrap to 0, 100 cycles per digit
        for (int i = 1; i <= 10; i++) begin
            drive(pat[i % 10]);
            wait_edges(5);
            check_eq("t2_digit", 32'(digit), 32'(i % 10));
            check_eq("t2_chg", 32'(change_strobe), 1);
            check_eq("t2_seq", 32'(seq_err), 0);
            if (i >= 2) check_eq("t2_period", 32'(period), 100);
            wait_edges(94);
        end
        check_eq("t2_chg_count", 32'(chg_n), 11);
        check_eq("t2_seq_count", 32'(seq_n), 0);

        // glitch to 8 while tracking 3
        hold(7'h06, 10);
        hold(7'h5B, 10);
        check_eq("t3_period10", 32'(period), 10);
        hold(7'h4F, 10);
        check_eq("t3_digit_pre", 32'(digit), 3);
        chg_mark = chg_n;
        hold(7'h7F, 2);
        hold(7'h4F, 10);
        check_eq("t3_digit", 32'(digit), 3);
        check_eq("t3_no_chg", 32'(chg_n), 32'(chg_mark));
        check_eq("t3_err", 32'(err_count), 0);

        // walk 4..9,0,1,2 in order
        for (int d = 4; d <= 12; d++) hold(pat[d % 10], 10);
        check_eq("t4_digit_pre", 32'(digit), 2);
        check_eq("t4_seq_none", 32'(seq_n), 0);

        // skip from 2 to 4
        drive(7'h66);
        wait_edges(5);
        check_eq("t4_seq", 32'(seq_err), 1);
        check_eq("t4_digit", 32'(digit), 4);
        check_eq("t4_err", 32'(err_count), 1);
        check_eq("t4_chg", 32'(change_strobe), 1);
        wait_edges(1);
        check_eq("t4_seq_width", 32'(seq_err), 0);
        wait_edges(3);
        hold(7'h6D, 10);
        check_eq("t4_digit5", 32'(digit), 5);
        check_eq("t4_err_keep", 32'(err_count), 1);
        check_eq("t4_seq_count", 32'(seq_n), 1);

        // illegal pattern then resync
        drive(7'h11);
        wait_edges(5);
        check_eq("t5_bad", 32'(bad_pattern), 1);
        check_eq("t5_valid", 32'(digit_valid), 0);
        check_eq("t5_err", 32'(err_count), 2);
        check_eq("t5_digit_hold", 32'(digit), 5);
        check_eq("t5_seq", 32'(seq_err), 0);
        wait_edges(1);
        check_eq("t5_bad_width", 32'(bad_pattern), 0);
        wait_edges(3);
        drive(7'h06);
        wait_edges(5);
        check_eq("t5_digit1", 32'(digit), 1);
        check_eq("t5_valid1", 32'(digit_valid), 1);
        check_eq("t5_chg", 32'(change_strobe), 1);
        check_eq("t5_seq_none", 32'(seq_err), 0);
        check_eq("t5_err_keep", 32'(err_count), 2);
        wait_edges(4);

        // build up to digit 7 with err_count 5
        hold(7'h4F, 10);
        check_eq("t6_err3", 32'(err_count), 3);
        hold(7'h7F, 10);
        check_eq("t6_err4", 32'(err_count), 4);
        hold(7'h11, 10);
        check_eq("t6_err5", 32'(err_count), 5);
        hold(7'h07, 10);
        check_eq("t6_digit7", 32'(digit), 7);
        check_eq("t6_valid7", 32'(digit_valid), 1);
        check_eq("t6_seq_count", 32'(seq_n), 3);
        check_eq("t6_bad_count", 32'(bad_n), 2);

        // asynchronous reset between edges
        drive(7'h4F);
        wait_edges(2);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_digit", 32'(digit), 0);
        check_eq("t6_rst_valid", 32'(digit_valid), 0);
        check_eq("t6_rst_err", 32'(err_count), 0);
        check_eq("t6_rst_period", 32'(period), 0);
        segments = 7'h00;
        wait_edges(3);
        @(negedge clk);
        rst = 1'b0;
        drive(7'h4F);
        wait_edges(4);
        check_eq("t6_early_valid", 32'(digit_valid), 0);
        wait_edges(1);
        check_eq("t6_post_digit", 32'(digit), 3);
        check_eq("t6_post_valid", 32'(digit_valid), 1);
        check_eq("t6_post_chg", 32'(change_strobe), 1);
        check_eq("t6_post_seq", 32'(seq_err), 0);
        check_eq("t6_post_err", 32'(err_count), 0);
        wait_edges(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side monitor for a seven-segment display bus, such as the `segments` output of the seconds counter.
- Filters glitches, decodes stable patterns back to BCD digits, and checks that digits advance by +1 mod 10.
- Measures the clock-cycle period between digit changes.
- Used in-bench and in loopback configurations to self-check a counter design without an external observer.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (legal range 1..15).
- PERIOD_W, 24: width of the period counter and `period` output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- segments  input  7  segment lines, active-high; bit0 = a … bit6 = g.
- digit  output  4  last accepted decoded digit, 0..9.
- digit_valid  output  1  high while `digit` holds a trusted value.
- change_strobe  output  1  one-cycle pulse when an accepted digit differs from the previous one.
- seq_err  output  1  one-cycle pulse when the new digit ≠ (previous + 1) mod 10.
- bad_pattern  output  1  one-cycle pulse when a stable pattern is not a legal digit or blank.
- period  output  PERIOD_W  clock edges between the last two change_strobes.
- err_count  output  8  saturating count of seq_err plus bad_pattern events.

Behaviour:
- Reset (asynchronous): all outputs are 0, state is SYNC, internal sample register is 0, stability counter is 0, period counter is 0.
- Input path:
  - `segments` is registered once into seg_q.
  - The stability counter resets to 0 whenever seg_q changes, otherwise increments, saturating at STABLE_CYCLES.
  - A pattern is accepted exactly once, on the edge where the counter reaches STABLE_CYCLES−1 (i.e. STABLE_CYCLES consecutive equal samples).
- Latency: if `segments` is stable before edge k, the resulting outputs are visible after edge k+STABLE_CYCLES.
- Legal patterns (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Pattern 00 is blank.
- Accepted blank: ignored completely; no output change.
- Accepted illegal pattern (any state):
  - bad_pattern pulses and err_count increments.
  - digit_valid is driven to 0, state becomes SYNC, and `digit` holds its value.
- State SYNC, legal digit accepted:
  - digit is loaded, digit_valid is driven to 1, and state goes to TRACK.
  - change_strobe pulses.
  - No seq_err is raised.
  - The period counter restarts at 0; `period` is not updated.
- State TRACK, legal digit accepted, equal to the current digit: no action (a glitch that returned to the same digit).
- State TRACK, legal digit accepted, different from the current digit:
  - change_strobe pulses and digit is loaded.
  - `period` ← period counter value + 1, then the counter restarts at 0.
  - If the new digit ≠ (old + 1) mod 10: seq_err pulses and err_count increments. State stays TRACK and the new digit becomes the reference.
- Wrap-around: a 9→0 transition is legal.
- Period counter: increments every cycle in TRACK and saturates at all-ones. A saturated value is reported as-is.
- err_count saturates at 255. seq_err and bad_pattern are mutually exclusive in any one cycle, since only one acceptance can occur per edge.
- Reset asserted mid-operation: immediate asynchronous clear; the first acceptance after release behaves as in SYNC.
- Strobe width: every pulse output is high for exactly one cycle.

Decomposition:
- Package `seven_seg_pkg` contains:
  - the localparam segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the function seg_to_digit(seg) → {legal, blank, digit[3:0]};
  - the state enum {SYNC, TRACK}.
- Sub-module `seg_stable_filter`, parameterised by STABLE_CYCLES: input register, stability counter, and an `accept` pulse with the held pattern.
- The top level contains the decode, the FSM, the period counter and err_count.

Test Plan:
- Reset, then drive 3F held for 10 cycles (STABLE_CYCLES=4) → after edge 4: digit=0, digit_valid=1, change_strobe pulse, period=0, err_count=0.
- Drive 3F,06,5B,…,6F,3F, each held 100 cycles → change_strobe every 100 cycles, period=100 from the second change onward, seq_err never asserted, 9→0 accepted.
- While tracking digit 3 (4F), glitch 7F for 2 cycles then return to 4F → no change_strobe, digit=3, err_count unchanged.
- Tracking digit 2, then drive 66 (digit 4) stable → seq_err pulse, digit=4, err_count=1; a following 6D (5) gives no error.
- Drive an illegal 7'h11 stable for 4 cycles → bad_pattern pulse, digit_valid=0, err_count+1; a next legal 06 → digit=1 with change_strobe and no seq_err.
- Assert rst asynchronously between clock edges mid-count, with digit=7 and err_count=5 → all outputs 0 immediately; after release, the first 4F is accepted in SYNC with no seq_err.
